ip_dec_rx: RTL

Receive-side assembler directly downstream of the ciphertext byte generator. Accepts the 10-bit tagged byte stream (2-bit rotating tag + 8-bit data, qualified by `req`) and checks the tag sequence. Rebuilds each 16-byte, MSB-first burst into one 128-bit ciphertext block and presents it to the XTEA decryption core over a valid/ready handshake. The byte source has no backpressure, so assembly and output are double-buffered.

---
 rtl/ip_dec_rx_pkg.sv | 20 ++
 rtl/ip_dec_rx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ip_dec_rx_pkg.sv
// Shared definitions for the ciphertext receive path: block geometry,
// receiver state encoding and the tagged-byte format used on the byte link.
package dec_pkg;

    localparam int BLK_W  = 128;
    localparam int NBYTES = 16;
    localparam int TAG_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [7:0]       data;
    } tag_byte_t;

endpackage

// File: rtl/ip_dec_rx.sv
// Receive-side assembler: checks the rotating tag sequence, rebuilds MSB-first
// bursts into ciphertext blocks and double-buffers them toward the XTEA core.
module ip_dec_rx
    import dec_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int TAG_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TAG_W+7:0]      data_in,
    input  logic                  req,
    output logic [8*NBYTES-1:0]   blk_out,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  err_tag,
    output logic                  err_ovf,
    output logic                  busy
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    rx_state_t        state_r;
    rx_state_t        state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [W-1:0]     asm_r;
    logic [W-1:0]     asm_s;
    logic [W-1:0]     out_s;
    logic             valid_s;
    logic             etag_s;
    logic             eovf_s;
    logic             busy_s;
    logic             done_s;
    logic             take_s;
    logic [W-1:0]     blk_new_s;
    logic [TAG_W-1:0] tag_s;
    logic [7:0]       byte_s;

    assign tag_s     = data_in[8 +: TAG_W];
    assign byte_s    = data_in[7:0];
    assign take_s    = blk_valid & blk_ready;
    assign blk_new_s = {asm_r[W-9:0], byte_s};

    // Next-state, tag check, assembly shift and output hand-off decision
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        asm_s   = asm_r;
        out_s   = blk_out;
        valid_s = blk_valid;
        etag_s  = 1'b0;
        eovf_s  = 1'b0;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (req) begin
                    if (tag_s == {TAG_W{1'b0}}) begin
                        asm_s   = blk_new_s;
                        idx_s   = IDX_W'(1);
                        state_s = COLLECT;
                    end else begin
                        etag_s  = 1'b1;
                        state_s = DISCARD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (req) begin
                    if (tag_s == idx_r[TAG_W-1:0]) begin
                        if (idx_r == LAST_IDX) begin
                            done_s  = 1'b1;
                            asm_s   = {W{1'b0}};
                            idx_s   = {IDX_W{1'b0}};
                            state_s = IDLE;
                        end else begin
                            asm_s = blk_new_s;
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        // Partial block is abandoned; the rest of the burst is skipped
                        etag_s  = 1'b1;
                        asm_s   = {W{1'b0}};
                        idx_s   = {IDX_W{1'b0}};
                        state_s = DISCARD;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            DISCARD: begin
                if (!req) begin
                    state_s = IDLE;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IDX_W{1'b0}};
                asm_s   = {W{1'b0}};
            end
        endcase

        // A consumer handshake on the completion edge frees the holding slot
        if (done_s) begin
            if (!blk_valid || take_s) begin
                out_s   = blk_new_s;
                valid_s = 1'b1;
            end else begin
                eovf_s  = 1'b1;
            end
        end else if (take_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = blk_valid;
        end

        busy_s = (state_s != IDLE);
    end

    // State, assembly and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            asm_r     <= {W{1'b0}};
            blk_out   <= {W{1'b0}};
            blk_valid <= 1'b0;
            err_tag   <= 1'b0;
            err_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            asm_r     <= asm_s;
            blk_out   <= out_s;
            blk_valid <= valid_s;
            err_tag   <= etag_s;
            err_ovf   <= eovf_s;
            busy      <= busy_s;
        end
    end

endmodule
